regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with NREAD combinational read ports, one synchronous write port, and a per-register pending-write scoreboard. It succeeds the fixed 32×32, 2-read single-cycle register file. It is the register file for the pipelined riscy32 cores: decode reads operands and checks hazards through `busy`, issue marks destinations pending, and writeback writes data and clears pending.

## Interface
Parameters:
- `XLEN`, 32, register data width.
- `NREG`, 32, number of registers (power of two, ≥2); register 0 hardwired to zero.
- `NREAD`, 2, number of read ports (1–4).
- Derived: `AW = $clog2(NREG)`, `CW = $clog2(NREG+1)`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ra`  in  NREAD*AW  read addresses; port i uses `ra[i*AW +: AW]`.
- `rd`  out  NREAD*XLEN  read data; port i at `rd[i*XLEN +: XLEN]`.
- `busy`  out  NREAD  bit i = register at port i is pending (hazard).
- `we3`  in  1  write enable (writeback).
- `a3`  in  AW  write address.
- `wd3`  in  XLEN  write data.
- `iss_v`  in  1  issue valid: mark `iss_rd` pending.
- `iss_rd`  in  AW  destination register being issued.
- `pend_cnt`  out  CW  number of registers currently pending.

## Operation
- Storage: registers 1..NREG-1 of XLEN bits, plus pending bits 1..NREG-1. Register 0 has no storage; it reads 0 and is never pending.
- Reads are combinational: `rd[i] = (ra[i]==0) ? 0 : regs[ra[i]]`.
- Write: on a rising edge with `we3=1` and `a3!=0`, `regs[a3] <= wd3`. Writes to register 0 are silently dropped.
- Pending bits, per rising edge, for register r≠0:
  - set if `iss_v && iss_rd==r`;
  - otherwise cleared if `we3 && a3==r`;
  - otherwise held.
  - Simultaneous issue and writeback to the same r leaves r pending: the new producer wins, and the data is still written.
- `iss_v` with `iss_rd==0` is ignored.
- Issuing to an already-pending register keeps it pending; `pend_cnt` is unchanged.
- `busy[i] = pend[ra[i]]`, masked as described under Configuration.
- `pend_cnt`: registered population count of the pending bits. It is updated incrementally each edge (+1 set, −1 clear, ±0 both or neither) and never wraps; the maximum is NREG-1.

## Timing
- Reset, asynchronous on `rst_n` low: all registers = 0, all pending = 0, `pend_cnt` = 0.
  - Outputs reflect this immediately: `rd` = 0 for every address, `busy` = 0.
  - Reset asserted mid-operation discards in-flight writes and issues in that cycle.
  - First update after release is on the first rising edge with `rst_n=1`.
- Write latency without bypass: data is visible on `rd` in the cycle after the write edge, which is 0 cycles after the edge, combinationally.
- Issue latency: `busy` rises in the cycle after the `iss_v` edge.
- `pend_cnt` reflects the edge at which the set or clear occurred.
- There is no back-pressure; every `we3`/`iss_v` is accepted every cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through forwarding.
  - If `we3 && a3!=0 && a3==ra[i]` in the current cycle, `rd[i] = wd3` and `busy[i] = 0` in the same cycle, before the edge.
  - Register-0 reads still return 0.
- Not defined:
  - `rd[i]` returns the stored value until the edge.
  - `busy[i]` stays 1 until the edge that clears it.
  - Decode must then stall one extra cycle.

## Test plan
- Reset: drive `rst_n=0` mid-cycle after writing `32'h12345678` to r1 → `rd` for r1 = 0 immediately, `busy` = 0, `pend_cnt` = 0.
- Write/read, NREAD=2: write r1 = `32'h12345678`, r2 = `32'h87654321`; `ra` = {2,1} → port0 = `12345678`, port1 = `87654321`. Write r0 = `32'hdeadbeef` → r0 reads 0.
- Scoreboard:
  - issue r5 → `busy` on a port reading r5 = 1, `pend_cnt` = 1;
  - issue r7 → `pend_cnt` = 2;
  - writeback r5 = `32'hcafef00d` → r5 `busy` = 0, `pend_cnt` = 1, r5 reads `cafef00d`.
- Collision: same edge `iss_v`/`iss_rd`=3 and `we3`/`a3`=3, `wd3`=`32'h0000aaaa`, with r3 previously pending → r3 stays pending, `pend_cnt` unchanged, r3 reads `0000aaaa`. Issue to r0 → `pend_cnt` unchanged.
- Bypass: with `we3=1`, `a3=4`, `wd3=32'h55aa55aa`, `ra[0]=4` before the edge → with `REGFILE_BYPASS_EN`, port0 = `55aa55aa` and `busy[0]=0` that cycle; without it, the old value and the old busy are shown until the edge.
- Saturation: issue all of r1..r(NREG-1) → `pend_cnt` = NREG-1; write them all back → `pend_cnt` = 0 with no underflow.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of the register-file access signals.
//   The master side (the pipeline) drives the read addresses, writeback and issue.
//   The slave side (regfile_sb) returns the read data, the busy flags and the pending count.
// Signals:
//   ra       NREAD*AW    read addresses; port i is ra[i*AW +: AW]
//   rd       NREAD*XLEN  read data; port i is rd[i*XLEN +: XLEN]
//   busy     NREAD       register on read port i has a pending write
//   we3      1           writeback enable
//   a3       AW          writeback address
//   wd3      XLEN        writeback data
//   iss_v    1           issue valid: mark iss_rd pending
//   iss_rd   AW          destination register being issued
//   pend_cnt CW          number of registers currently pending
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
) ();
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic [NREAD-1:0]      busy;
  logic                  we3;
  logic [AW-1:0]         a3;
  logic [XLEN-1:0]       wd3;
  logic                  iss_v;
  logic [AW-1:0]         iss_rd;
  logic [CW-1:0]         pend_cnt;

  modport master (
    output ra, we3, a3, wd3, iss_v, iss_rd,
    input  rd, busy, pend_cnt
  );

  modport slave (
    input  ra, we3, a3, wd3, iss_v, iss_rd,
    output rd, busy, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with NREAD combinational read ports,
// one synchronous write port and a per-register pending-write scoreboard.
// Register 0 reads as zero and is never pending.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset (clears data, pending bits and count)
//   bus    regfile_sb_if.slave (ra/rd/busy read side, we3/a3/wd3 writeback,
//          iss_v/iss_rd issue, pend_cnt pending population count)
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a writeback in the current cycle is
//                      forwarded to matching read ports (rd = wd3, busy = 0)
//                      before the edge. Undefined: reads show stored state.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  // Entry 0 is held at zero forever and folds away in synthesis.
  logic [XLEN-1:0]       regs_q [NREG];
  logic [NREG-1:0]       pend_q;
  logic [NREG-1:0]       pend_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  wr_s;
  logic                  iss_s;
  logic                  set_s;
  logic                  clr_s;
  logic [AW-1:0]         addr_s [NREAD];
  logic [NREAD*XLEN-1:0] rd_s;
  logic [NREAD-1:0]      busy_s;

  // Qualify writeback and issue: register 0 targets are ignored.
  always_comb begin
    wr_s  = bus.we3   && (bus.a3     != {AW{1'b0}});
    iss_s = bus.iss_v && (bus.iss_rd != {AW{1'b0}});
  end

  // Next pending vector: issue set overrides writeback clear on the same register.
  always_comb begin
    pend_d = pend_q;
    if (wr_s) begin
      pend_d[bus.a3] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (iss_s) begin
      pend_d[bus.iss_rd] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // Incremental pending count: a set only counts if the bit was clear, a clear
  // only counts if the bit was set and not re-issued on the same edge.
  always_comb begin
    set_s = iss_s && !pend_q[bus.iss_rd];
    clr_s = wr_s && pend_q[bus.a3] && !(iss_s && (bus.iss_rd == bus.a3));
    case ({set_s, clr_s})
      2'b10:   cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  // Register storage: synchronous write port, register 0 pinned to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q[0] <= {XLEN{1'b0}};
      for (int r = 1; r < NREG; r++) begin
        if (wr_s && (bus.a3 == AW'(r))) begin
          regs_q[r] <= bus.wd3;
        end
      end
    end
  end

  // Scoreboard state: pending bits and their population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= {NREG{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Split the packed read-address bus into per-port addresses.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      addr_s[i] = bus.ra[i*AW +: AW];
    end
  end

  // Combinational read ports with hazard flags.
  always_comb begin
    rd_s   = {(NREAD*XLEN){1'b0}};
    busy_s = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      if (addr_s[i] != {AW{1'b0}}) begin
        rd_s[i*XLEN +: XLEN] = regs_q[addr_s[i]];
        busy_s[i]            = pend_q[addr_s[i]];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback so decode need not wait for the edge.
        if (wr_s && (bus.a3 == addr_s[i])) begin
          rd_s[i*XLEN +: XLEN] = bus.wd3;
          busy_s[i]            = 1'b0;
        end else begin
          busy_s[i]            = pend_q[addr_s[i]];
        end
`endif
      end else begin
        rd_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
        busy_s[i]            = 1'b0;
      end
    end
  end

  assign bus.rd       = rd_s;
  assign bus.busy     = busy_s;
  assign bus.pend_cnt = cnt_q;

endmodule
